// File: rtl/core_pkg.sv
// Shared decode-stage definitions: immediate extension modes and instruction field positions.
package core_pkg;

  typedef enum logic [2:0] {
    EXT_B  = 3'd0,
    EXT_CB = 3'd1,
    EXT_D  = 3'd2,
    EXT_I  = 3'd3,
    EXT_IW = 3'd4
  } ext_mode_t;

  localparam int unsigned B_MSB  = 25;
  localparam int unsigned CB_MSB = 23;
  localparam int unsigned CB_LSB = 5;
  localparam int unsigned D_MSB  = 20;
  localparam int unsigned D_LSB  = 12;
  localparam int unsigned I_MSB  = 21;
  localparam int unsigned I_LSB  = 10;
  localparam int unsigned IW_MSB = 20;
  localparam int unsigned IW_LSB = 5;
  localparam int unsigned HW_MSB = 22;
  localparam int unsigned HW_LSB = 21;

  localparam int unsigned B_W  = B_MSB + 1;
  localparam int unsigned CB_W = CB_MSB - CB_LSB + 1;
  localparam int unsigned D_W  = D_MSB - D_LSB + 1;
  localparam int unsigned I_W  = I_MSB - I_LSB + 1;
  localparam int unsigned IW_W = IW_MSB - IW_LSB + 1;

  localparam int unsigned WIDE_W = 64;

endpackage

// File: rtl/imm_ext_pipe_if.sv
// Handshake bundle between decode, the immediate unit and register read.
interface imm_ext_pipe_if #(
  parameter int unsigned OUT_W = 64
);
  logic             flush;
  logic             in_valid;
  logic             in_ready;
  logic [31:0]      in_instr;
  logic [2:0]       in_mode;
  logic             out_valid;
  logic             out_ready;
  logic [OUT_W-1:0] out_imm;
  logic             out_err;

  modport master (
    output flush, in_valid, in_instr, in_mode, out_ready,
    input  in_ready, out_valid, out_imm, out_err
  );

  modport slave (
    input  flush, in_valid, in_instr, in_mode, out_ready,
    output in_ready, out_valid, out_imm, out_err
  );
endinterface

// File: rtl/imm_ext_pipe_comb.sv
// Combinational immediate field select, sign/zero extension and scaling.
module imm_ext_comb
  import core_pkg::*;
#(
  parameter int unsigned OUT_W    = 64,
  parameter bit          SHIFT_BR = 1'b1
) (
  input  logic [31:0]      instr_i,
  input  logic [2:0]       mode_i,
  output logic [OUT_W-1:0] imm_o,
  output logic             err_o
);

  logic [WIDE_W-1:0] wide;

  always_comb begin
    wide  = '0;
    err_o = 1'b0;
    case (mode_i)
      EXT_B: begin
        wide = {{(WIDE_W-B_W){instr_i[B_MSB]}}, instr_i[B_MSB:0]};
        if (SHIFT_BR) wide = {wide[WIDE_W-3:0], 2'b00};
      end
      EXT_CB: begin
        wide = {{(WIDE_W-CB_W){instr_i[CB_MSB]}}, instr_i[CB_MSB:CB_LSB]};
        if (SHIFT_BR) wide = {wide[WIDE_W-3:0], 2'b00};
      end
      EXT_D:  wide = {{(WIDE_W-D_W){instr_i[D_MSB]}}, instr_i[D_MSB:D_LSB]};
      EXT_I:  wide = {{(WIDE_W-I_W){1'b0}}, instr_i[I_MSB:I_LSB]};
      // Halfword position selects a 0/16/32/48-bit shift.
      EXT_IW: wide = {{(WIDE_W-IW_W){1'b0}}, instr_i[IW_MSB:IW_LSB]}
                     << {instr_i[HW_MSB:HW_LSB], 4'b0000};
      default: err_o = 1'b1;
    endcase
  end

  assign imm_o = wide[OUT_W-1:0];

  logic unused_instr;
  assign unused_instr = ^instr_i[31:26];

  if (OUT_W < WIDE_W) begin : g_trunc
    logic unused_hi;
    assign unused_hi = ^wide[WIDE_W-1:OUT_W];
  end

endmodule

// File: rtl/imm_ext_pipe.sv
// Registered immediate extraction with a 2-entry skid buffer and flush.
module imm_ext_pipe
  import core_pkg::*;
#(
  parameter int unsigned OUT_W    = 64,
  parameter bit          SHIFT_BR = 1'b1
) (
  input logic           clk,
  input logic           reset_n,
  imm_ext_pipe_if.slave bus
);

  logic [OUT_W-1:0] new_imm;
  logic             new_err;

  imm_ext_comb #(
    .OUT_W    (OUT_W),
    .SHIFT_BR (SHIFT_BR)
  ) u_comb (
    .instr_i (bus.in_instr),
    .mode_i  (bus.in_mode),
    .imm_o   (new_imm),
    .err_o   (new_err)
  );

  logic [1:0]       count_q, count_d;
  logic [OUT_W-1:0] imm_q [2];
  logic [OUT_W-1:0] imm_d [2];
  logic [1:0]       err_q, err_d;
  logic             push, pop;
  logic [1:0]       wr_pos;

  assign bus.in_ready  = (count_q < 2'd2) && reset_n && !bus.flush;
  assign bus.out_valid = (count_q != 2'd0);
  assign bus.out_imm   = imm_q[0];
  assign bus.out_err   = err_q[0];

  assign push   = bus.in_valid && bus.in_ready;
  assign pop    = bus.out_valid && bus.out_ready;
  // Slot the new entry lands in once any same-cycle pop has shifted the buffer.
  assign wr_pos = count_q - {1'b0, pop};

  always_comb begin
    count_d = count_q;
    imm_d   = imm_q;
    err_d   = err_q;
    if (bus.flush) begin
      count_d = 2'd0;
    end else begin
      if (pop) begin
        imm_d[0] = imm_q[1];
        err_d[0] = err_q[1];
      end
      if (push) begin
        imm_d[wr_pos[0]] = new_imm;
        err_d[wr_pos[0]] = new_err;
      end
      count_d = count_q + {1'b0, push} - {1'b0, pop};
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      count_q  <= 2'd0;
      imm_q[0] <= '0;
      imm_q[1] <= '0;
      err_q    <= 2'b00;
    end else begin
      count_q <= count_d;
      imm_q   <= imm_d;
      err_q   <= err_d;
    end
  end

endmodule

// File: tb/tb_imm_ext_pipe.sv
// Directed bench: table-driven extension vectors plus handshake, flush and reset sequences.
module tb_imm_ext_pipe;

  logic        clk = 1'b0;
  logic        reset_n;
  logic        flush;
  logic        in_valid;
  logic [31:0] in_instr;
  logic [2:0]  in_mode;
  logic        out_ready;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  imm_ext_pipe_if #(.OUT_W(64)) bus64 ();
  imm_ext_pipe_if #(.OUT_W(64)) busns ();
  imm_ext_pipe_if #(.OUT_W(32)) bus32 ();

  assign bus64.flush = flush;     assign busns.flush = flush;     assign bus32.flush = flush;
  assign bus64.in_valid = in_valid;
  assign busns.in_valid = in_valid;
  assign bus32.in_valid = in_valid;
  assign bus64.in_instr = in_instr;
  assign busns.in_instr = in_instr;
  assign bus32.in_instr = in_instr;
  assign bus64.in_mode = in_mode; assign busns.in_mode = in_mode; assign bus32.in_mode = in_mode;
  assign bus64.out_ready = out_ready;
  assign busns.out_ready = out_ready;
  assign bus32.out_ready = out_ready;

  imm_ext_pipe #(.OUT_W(64), .SHIFT_BR(1'b1)) dut (
    .clk (clk), .reset_n (reset_n), .bus (bus64.slave)
  );
  imm_ext_pipe #(.OUT_W(64), .SHIFT_BR(1'b0)) dut_ns (
    .clk (clk), .reset_n (reset_n), .bus (busns.slave)
  );
  imm_ext_pipe #(.OUT_W(32), .SHIFT_BR(1'b1)) dut_32 (
    .clk (clk), .reset_n (reset_n), .bus (bus32.slave)
  );

  typedef struct {
    logic [31:0] instr;
    logic [2:0]  mode;
    logic [63:0] exp_imm;
    logic [63:0] exp_ns;
    logic [31:0] exp_32;
    logic        exp_err;
  } vec_t;

  localparam int NV = 14;
  vec_t vecs [NV];

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h, expected %h", name, act, exp);
    end
  endtask

  function automatic logic [31:0] i_instr(input logic [11:0] v);
    return {10'b0, v, 10'b0};
  endfunction

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1);
  end

  initial begin
    vecs[0]  = '{32'h0200_0000, 3'd0, 64'hFFFFFFFF_F8000000, 64'hFFFFFFFF_FE000000, 32'hF8000000, 1'b0};
    vecs[1]  = '{32'h0000_0123, 3'd0, 64'h48C, 64'h123, 32'h48C, 1'b0};
    vecs[2]  = '{32'hFC00_0001, 3'd0, 64'h4, 64'h1, 32'h4, 1'b0};
    vecs[3]  = '{32'h00FF_FFE0, 3'd1, 64'hFFFFFFFF_FFFFFFFC, 64'hFFFFFFFF_FFFFFFFF, 32'hFFFFFFFC, 1'b0};
    vecs[4]  = '{32'hFF00_0020, 3'd1, 64'h4, 64'h1, 32'h4, 1'b0};
    vecs[5]  = '{32'h0010_0000, 3'd2, 64'hFFFFFFFF_FFFFFF00, 64'hFFFFFFFF_FFFFFF00, 32'hFFFFFF00, 1'b0};
    vecs[6]  = '{32'h000F_F000, 3'd2, 64'hFF, 64'hFF, 32'hFF, 1'b0};
    vecs[7]  = '{32'h003F_FC00, 3'd3, 64'hFFF, 64'hFFF, 32'hFFF, 1'b0};
    vecs[8]  = '{32'hFFC0_03FF, 3'd3, 64'h0, 64'h0, 32'h0, 1'b0};
    vecs[9]  = '{32'h0055_79A0, 3'd4, 64'h0000ABCD_00000000, 64'h0000ABCD_00000000, 32'h0, 1'b0};
    vecs[10] = '{32'h0075_79A0, 3'd4, 64'hABCD0000_00000000, 64'hABCD0000_00000000, 32'h0, 1'b0};
    vecs[11] = '{32'h0015_79A0, 3'd4, 64'hABCD, 64'hABCD, 32'hABCD, 1'b0};
    vecs[12] = '{32'hFFFF_FFFF, 3'd6, 64'h0, 64'h0, 32'h0, 1'b1};
    vecs[13] = '{32'h0200_0000, 3'd7, 64'h0, 64'h0, 32'h0, 1'b1};

    reset_n = 1'b0; flush = 1'b0; in_valid = 1'b0; in_instr = '0; in_mode = '0; out_ready = 1'b0;
    #12;
    check("reset in_ready", {63'b0, bus64.in_ready}, 64'd0);
    check("reset out_valid", {63'b0, bus64.out_valid}, 64'd0);
    check("reset out_imm", bus64.out_imm, 64'd0);
    check("reset out_err", {63'b0, bus64.out_err}, 64'd0);
    #10;
    reset_n = 1'b1;
    step();
    check("post-reset in_ready", {63'b0, bus64.in_ready}, 64'd1);

    // Table: single entry through an empty buffer, out_ready held high.
    out_ready = 1'b1;
    for (int i = 0; i < NV; i++) begin
      in_valid = 1'b1;
      in_instr = vecs[i].instr;
      in_mode  = vecs[i].mode;
      step();
      in_valid = 1'b0;
      check($sformatf("vec%0d valid", i), {63'b0, bus64.out_valid}, 64'd1);
      check($sformatf("vec%0d imm", i), bus64.out_imm, vecs[i].exp_imm);
      check($sformatf("vec%0d imm_noshift", i), busns.out_imm, vecs[i].exp_ns);
      check($sformatf("vec%0d imm_w32", i), {32'b0, bus32.out_imm}, {32'b0, vecs[i].exp_32});
      check($sformatf("vec%0d err", i), {63'b0, bus64.out_err}, {63'b0, vecs[i].exp_err});
      step();
      check($sformatf("vec%0d drained", i), {63'b0, bus64.out_valid}, 64'd0);
    end

    // Backpressure: A, B fill the buffer, C waits for space.
    out_ready = 1'b0; in_mode = 3'd3;
    in_valid = 1'b1; in_instr = i_instr(12'h0A1);
    step();
    check("bp head A", bus64.out_imm, 64'h0A1);
    in_instr = i_instr(12'h0B2);
    step();
    check("bp full in_ready", {63'b0, bus64.in_ready}, 64'd0);
    in_instr = i_instr(12'h0C3);
    step();
    check("bp hold A", bus64.out_imm, 64'h0A1);
    check("bp hold valid", {63'b0, bus64.out_valid}, 64'd1);
    out_ready = 1'b1;
    step();
    check("bp pop B", bus64.out_imm, 64'h0B2);
    check("bp ready again", {63'b0, bus64.in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("bp push+pop C", bus64.out_imm, 64'h0C3);
    check("bp push+pop valid", {63'b0, bus64.out_valid}, 64'd1);
    step();
    check("bp empty", {63'b0, bus64.out_valid}, 64'd0);

    // Flush with a full buffer, a same-cycle input and a same-cycle pop.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = i_instr(12'h011);
    step();
    in_instr = i_instr(12'h022);
    step();
    flush = 1'b1; in_instr = i_instr(12'h033); out_ready = 1'b1;
    #1;
    check("flush in_ready", {63'b0, bus64.in_ready}, 64'd0);
    step();
    check("flush out_valid", {63'b0, bus64.out_valid}, 64'd0);
    flush = 1'b0; in_valid = 1'b0;
    step();
    check("flush no leak", {63'b0, bus64.out_valid}, 64'd0);
    in_valid = 1'b1; in_instr = i_instr(12'h044);
    step();
    in_valid = 1'b0;
    check("flush next head", bus64.out_imm, 64'h044);
    check("flush next valid", {63'b0, bus64.out_valid}, 64'd1);
    step();

    // Asynchronous reset mid-stream with two entries held, head illegal.
    out_ready = 1'b0;
    in_valid = 1'b1; in_instr = 32'h1234_5678; in_mode = 3'd6;
    step();
    check("illegal err", {63'b0, bus64.out_err}, 64'd1);
    check("illegal imm", bus64.out_imm, 64'd0);
    in_instr = i_instr(12'h055); in_mode = 3'd3;
    step();
    in_valid = 1'b0;
    #2;
    reset_n = 1'b0;
    #1;
    check("async rst valid", {63'b0, bus64.out_valid}, 64'd0);
    check("async rst in_ready", {63'b0, bus64.in_ready}, 64'd0);
    check("async rst err", {63'b0, bus64.out_err}, 64'd0);
    #2;
    reset_n = 1'b1;
    in_valid = 1'b1; in_instr = i_instr(12'h066);
    #1;
    check("rst release in_ready", {63'b0, bus64.in_ready}, 64'd1);
    step();
    in_valid = 1'b0;
    check("rst first accept", bus64.out_imm, 64'h066);
    check("rst first valid", {63'b0, bus64.out_valid}, 64'd1);
    out_ready = 1'b1;
    step();
    check("rst drained", {63'b0, bus64.out_valid}, 64'd0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule

// File: doc/imm_ext_pipe.md
Name: imm_ext_pipe

Overview:
Parametrised, registered immediate-extraction unit for the decode stage of the 5-stage ARM core. It selects the immediate field from a 32-bit instruction by extension mode, then sign- or zero-extends it, optionally scales it, and produces an OUT_W-bit value. Results pass through a 2-entry skid buffer with valid/ready handshakes on both sides, so the unit decouples decode from register-read stalls. A flush input drops all held results on a branch mispredict.

Parameters:
OUT_W, 64, output immediate width; legal range 32..64; bits above OUT_W are truncated.
SHIFT_BR, 1, when 1, B and CB immediates are shifted left by 2 (word offset to byte offset).

Ports:
clk  in  1  core clock, all state on rising edge
reset_n  in  1  asynchronous active-low reset
flush  in  1  synchronous; discards all buffered entries and any same-cycle input
in_valid  in  1  instr/mode are valid this cycle
in_ready  out  1  unit can accept an input this cycle
in_instr  in  32  raw instruction word
in_mode  in  3  extension mode, ext_mode_t
out_valid  out  1  out_imm/out_err are valid
out_ready  in  1  consumer accepts the output this cycle
out_imm  out  OUT_W  extended immediate
out_err  out  1  entry was produced from an illegal mode code

Behaviour:
- Reset (reset_n low, asynchronous): entry count = 0, out_valid = 0, out_imm = 0, out_err = 0. in_ready is 0 while reset_n is low.
- Modes:
  - EXT_B (0): instr[25:0], sign-extended.
  - EXT_CB (1): instr[23:5], sign-extended.
  - EXT_D (2): instr[20:12], sign-extended.
  - EXT_I (3): instr[21:10], zero-extended.
  - EXT_IW (4): instr[20:5], zero-extended, then shifted left by 16*instr[22:21].
  - Codes 5..7 are illegal: imm = 0, err = 1.
  - With SHIFT_BR = 1, B and CB results are shifted left by 2 after extension. The sign bit is replicated into bits above the field and the shift result is truncated to OUT_W.
- Extension is combinational on the input side; only the result {imm, err} is stored.
- Handshake:
  - Accept when in_valid && in_ready. Pop when out_valid && out_ready.
  - in_ready = (count < 2) && reset_n && !flush.
  - out_valid = (count > 0).
  - out_imm/out_err always show the head entry. They hold their value while out_valid && !out_ready.
- Latency: an input accepted at edge N is visible on out_* after edge N, provided the buffer was empty. When out_ready is held high, throughput is one result per cycle.
- Ordering: strict FIFO. The head entry is the oldest.
- Boundaries:
  - Simultaneous push and pop with count = 1: count stays 1, and the new entry becomes the head after the edge.
  - Push and pop with count = 2 cannot occur, because in_ready = 0.
  - Pop with count = 0 is ignored.
  - flush: at the next edge count = 0 and out_valid = 0. An input with in_valid high in the same cycle is dropped. A pop in the same cycle is also discarded, since flush wins. out_imm is don't-care once out_valid is low.
  - Reset asserted mid-stream clears everything immediately, with no partial results. After reset_n deasserts, the first accept is possible on the next edge.
- No combinational path from out_ready to in_ready is required. in_ready depends only on registered count, reset_n and flush.

Decomposition:
- Package core_pkg holds:
  - typedef enum logic [2:0] ext_mode_t {EXT_B, EXT_CB, EXT_D, EXT_I, EXT_IW}.
  - Field-position constants: B_MSB = 25, CB_MSB = 23, CB_LSB = 5, D_MSB = 20, D_LSB = 12, I_MSB = 21, I_LSB = 10, IW_MSB = 20, IW_LSB = 5, HW_MSB = 22, HW_LSB = 21.
- One sub-module, imm_ext_comb: purely combinational mode-select and extend, with parameter OUT_W. The top level holds the 2-entry buffer, the count and the handshake logic.

Test Plan:
1. EXT_B, instr[25:0] = 26'h2000000, SHIFT_BR = 1, out_ready = 1 -> next cycle out_imm = 64'hFFFFFFFF_F8000000, out_err = 0. Repeat with SHIFT_BR = 0 -> 64'hFFFFFFFF_FE000000.
2. EXT_CB with instr[23:5] = 19'h7FFFF -> 64'hFFFFFFFF_FFFFFFFC. EXT_D with instr[20:12] = 9'h100 -> 64'hFFFFFFFF_FFFFFF00. EXT_I with instr[21:10] = 12'hFFF -> 64'h00000000_00000FFF.
3. EXT_IW with instr[20:5] = 16'hABCD and hw = 2 -> 64'h0000ABCD_00000000. Same with hw = 3 and OUT_W = 32 -> 32'h00000000 (truncated).
4. Backpressure: out_ready = 0, push 3 back-to-back inputs -> first two accepted, in_ready drops after the second, the third is held by the source. Raise out_ready -> outputs appear in order, one per cycle, with no loss or duplication.
5. Flush with count = 2, in_valid = 1 and out_ready = 1 in the same cycle -> after the edge out_valid = 0, count = 0, and the same-cycle input never appears at the output.
6. Illegal mode 3'd6 -> out_imm = 0, out_err = 1. Assert reset_n low asynchronously mid-stream with 2 entries held -> out_valid falls immediately, without waiting for a clock edge.
